// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared state encoding and sizing helpers for the data-memory responder
package data_mem_responder_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10} state_t;
  localparam int WORD_BYTES = 4;
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: word storage with synchronous write, combinational read and synchronous clear
module data_mem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data-memory responder that stalls the pipeline per access
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemAdr,
  input  logic [31:0] MemWriteData,
  input  logic        MemoryRead,
  input  logic        MemoryWrite,
  output logic [31:0] MemReadData,
  output logic        Stall
);
  localparam int IW = idx_width(DEPTH);
  state_t          state, state_nx;
  logic [3:0]      cnt;
  logic            op_wr, a_wr, req, access, unused_adr;
  logic [IW-1:0]   idx, a_idx;
  logic [31:0]     wdata, a_wdata, rdata;
  assign req = MemoryRead | MemoryWrite;
  assign unused_adr = ^{MemAdr[31:IW+2], MemAdr[1:0]};
  // With LATENCY==1 the access happens on the accepting edge, so the live inputs stand in for the latch
  assign a_idx   = state == IDLE ? MemAdr[IW+1:2] : idx;
  assign a_wr    = state == IDLE ? MemoryWrite : op_wr;
  assign a_wdata = state == IDLE ? MemWriteData : wdata;
  always_comb begin
    state_nx = state;
    access   = 1'b0;
    if (state == IDLE && req) begin
      state_nx = LATENCY == 1 ? DONE : WAIT;
      access   = LATENCY == 1;
    end else if (state == WAIT && cnt == 4'd0) begin
      state_nx = DONE;
      access   = 1'b1;
    end else if (state != IDLE && state != WAIT) begin
      state_nx = IDLE;
    end
    Stall = !rst && ((state == IDLE && req) || state == WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      idx         <= '0;
      wdata       <= '0;
      MemReadData <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        op_wr <= MemoryWrite;
        idx   <= MemAdr[IW+1:2];
        wdata <= MemWriteData;
        cnt   <= 4'(LATENCY - 2);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !a_wr) MemReadData <= rdata;
    end
  end
  data_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (access && a_wr && !rst),
    .addr (a_idx),
    .wdata(a_wdata),
    .rdata(rdata)
  );
endmodule
